// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundle between the 5-stage pipeline and its sequencing controller.
//   Pipeline -> controller : ID source registers and read flags, EX
//                            destination/write/load info, EX redirect, data
//                            memory request/ready.
//   Controller -> pipeline : enable and flush strobes for PC, IF_ID, ID_EX,
//                            EX_MEM and MEM_WB.
//   modport master : pipeline side (drives status, receives enables/flushes)
//   modport slave  : controller side (hazard_ctrl)
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_reg_write;
  logic       ex_is_load;
  logic       redirect;
  logic       dmem_req;
  logic       dmem_ready;

  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_en;
  logic       id_ex_flush;
  logic       ex_mem_en;
  logic       mem_wb_en;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rd, ex_reg_write, ex_is_load, redirect,
    output dmem_req, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    input  ex_mem_en, mem_wb_en
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rd, ex_reg_write, ex_is_load, redirect,
    input  dmem_req, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    output ex_mem_en, mem_wb_en
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencing controller for the 5-stage RISC-V core.
//   - Load-use hazards: holds PC/IF_ID and loads LOAD_LAT bubbles into ID_EX.
//   - EX redirect: squashes IF_ID and ID_EX (two wrong-path slots).
//   - Data memory busy: freezes every pipeline register.
//   Priority per cycle: memory freeze > redirect > load-use bubble.
//
// Ports
//   clk            clock
//   resetn         synchronous, active-low reset
//   pipe           hazard_ctrl_if.slave: pipeline status in, enables/flushes out
//   stall_cnt_o    load-use bubble cycles        (performance counter)
//   flush_cnt_o    redirect events acted on      (performance counter)
//   memwait_cnt_o  memory freeze cycles          (performance counter)
//
// Parameters
//   LOAD_LAT  bubbles per load-use hazard, 1..3
//   CNT_W     performance counter width
//
// Build option
//   HAZ_PERF_CNT_EN : when defined, the three saturating performance counters
//                     are built; otherwise the counter outputs are tied to 0.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  hazard_ctrl_if.slave     pipe,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] memwait_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    MWAIT = 2'd2
  } state_t;

  // Bubbles still owed after the first one, loaded on entry to STALL.
  localparam logic [1:0] BUB_INIT = 2'(LOAD_LAT - 1);

  state_t     state_q, state_d;
  logic [1:0] bub_left_q, bub_left_d;

  logic memstall;
  logic hz;
  logic bubble_issue;   // a load-use bubble goes into ID_EX this cycle
  logic flush_act;      // a redirect is acted on this cycle

  logic pc_en_d, if_id_en_d, if_id_flush_d, id_ex_en_d, id_ex_flush_d;
  logic ex_mem_en_d, mem_wb_en_d;

  assign memstall = pipe.dmem_req & ~pipe.dmem_ready;

  assign hz = pipe.ex_is_load & pipe.ex_reg_write & (pipe.ex_rd != 5'd0) &
              ((pipe.id_uses_rs1 & (pipe.id_rs1 == pipe.ex_rd)) |
               (pipe.id_uses_rs2 & (pipe.id_rs2 == pipe.ex_rd)));

  always_comb begin
    state_d       = state_q;
    bub_left_d    = bub_left_q;
    bubble_issue  = 1'b0;
    flush_act     = 1'b0;
    pc_en_d       = 1'b1;
    if_id_en_d    = 1'b1;
    if_id_flush_d = 1'b0;
    id_ex_en_d    = 1'b1;
    id_ex_flush_d = 1'b0;
    ex_mem_en_d   = 1'b1;
    mem_wb_en_d   = 1'b1;

    if (!resetn) begin
      // Hold everything and present NOPs at IF_ID / ID_EX while in reset.
      pc_en_d       = 1'b0;
      if_id_en_d    = 1'b0;
      if_id_flush_d = 1'b1;
      id_ex_en_d    = 1'b0;
      id_ex_flush_d = 1'b1;
      ex_mem_en_d   = 1'b0;
      mem_wb_en_d   = 1'b0;
      state_d       = RUN;
      bub_left_d    = 2'd0;
    end else if (memstall) begin
      // Full freeze. A pending redirect or hazard stays on the held inputs
      // and is evaluated once memory is done; STALL keeps its bubble count.
      pc_en_d     = 1'b0;
      if_id_en_d  = 1'b0;
      id_ex_en_d  = 1'b0;
      ex_mem_en_d = 1'b0;
      mem_wb_en_d = 1'b0;
      if (state_q == RUN) begin
        state_d = MWAIT;
      end
    end else if (pipe.redirect) begin
      if_id_flush_d = 1'b1;
      id_ex_flush_d = 1'b1;
      flush_act     = 1'b1;
      state_d       = RUN;
      bub_left_d    = 2'd0;
    end else if (state_q == STALL) begin
      // The hazard is not re-checked here: the load is still working its
      // way down and the owed bubble count alone decides when to resume.
      pc_en_d       = 1'b0;
      if_id_en_d    = 1'b0;
      id_ex_flush_d = 1'b1;
      bubble_issue  = 1'b1;
      bub_left_d    = bub_left_q - 2'd1;
      if (bub_left_q == 2'd1) begin
        state_d = RUN;
      end
    end else begin
      // RUN, or the first cycle after a freeze (MWAIT acts as RUN).
      state_d = RUN;
      if (hz) begin
        pc_en_d       = 1'b0;
        if_id_en_d    = 1'b0;
        id_ex_flush_d = 1'b1;
        bubble_issue  = 1'b1;
        if (LOAD_LAT > 1) begin
          state_d    = STALL;
          bub_left_d = BUB_INIT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= RUN;
      bub_left_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      bub_left_q <= bub_left_d;
    end
  end

  assign pipe.pc_en       = pc_en_d;
  assign pipe.if_id_en    = if_id_en_d;
  assign pipe.if_id_flush = if_id_flush_d;
  assign pipe.id_ex_en    = id_ex_en_d;
  assign pipe.id_ex_flush = id_ex_flush_d;
  assign pipe.ex_mem_en   = ex_mem_en_d;
  assign pipe.mem_wb_en   = mem_wb_en_d;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] memwait_cnt_q;

  // Saturating counters: they stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      if (bubble_issue && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_act && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
      if (memstall && (memwait_cnt_q != '1)) begin
        memwait_cnt_q <= memwait_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign memwait_cnt_o = memwait_cnt_q;
`else
  // Event strobes only feed the counters; keep them visible but unused.
  logic unused_perf_events;
  assign unused_perf_events = bubble_issue ^ flush_act;

  assign stall_cnt_o   = '0;
  assign flush_cnt_o   = '0;
  assign memwait_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam logic [6:0] V_NORM   = 7'b1101011;
  localparam logic [6:0] V_BUB    = 7'b0001111;
  localparam logic [6:0] V_FLUSH  = 7'b1111111;
  localparam logic [6:0] V_FREEZE = 7'b0000000;
  localparam logic [6:0] V_RST    = 7'b0010100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [4:0] rs1, rs2, exrd;
  logic       u1, u2, regwr, isld, redir, dreq, drdy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  hazard_ctrl_if if1();
  hazard_ctrl_if if3();

  assign if1.id_rs1 = rs1;        assign if3.id_rs1 = rs1;
  assign if1.id_rs2 = rs2;        assign if3.id_rs2 = rs2;
  assign if1.id_uses_rs1 = u1;    assign if3.id_uses_rs1 = u1;
  assign if1.id_uses_rs2 = u2;    assign if3.id_uses_rs2 = u2;
  assign if1.ex_rd = exrd;        assign if3.ex_rd = exrd;
  assign if1.ex_reg_write = regwr; assign if3.ex_reg_write = regwr;
  assign if1.ex_is_load = isld;   assign if3.ex_is_load = isld;
  assign if1.redirect = redir;    assign if3.redirect = redir;
  assign if1.dmem_req = dreq;     assign if3.dmem_req = dreq;
  assign if1.dmem_ready = drdy;   assign if3.dmem_ready = drdy;

  logic [31:0] sc1, fc1, mc1;
  logic [2:0]  sc3, fc3, mc3;

  hazard_ctrl #(.LOAD_LAT(1), .CNT_W(32)) dut1 (
    .clk(clk), .resetn(resetn), .pipe(if1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1), .memwait_cnt_o(mc1)
  );

  hazard_ctrl #(.LOAD_LAT(3), .CNT_W(3)) dut3 (
    .clk(clk), .resetn(resetn), .pipe(if3),
    .stall_cnt_o(sc3), .flush_cnt_o(fc3), .memwait_cnt_o(mc3)
  );

  // Index 0: LOAD_LAT=1, CNT_W=32.  Index 1: LOAD_LAT=3, CNT_W=3.
  logic [6:0]  o [2];
  logic [31:0] st_c [2];
  logic [31:0] fl_c [2];
  logic [31:0] mw_c [2];
  assign o[0] = {if1.pc_en, if1.if_id_en, if1.if_id_flush, if1.id_ex_en,
                 if1.id_ex_flush, if1.ex_mem_en, if1.mem_wb_en};
  assign o[1] = {if3.pc_en, if3.if_id_en, if3.if_id_flush, if3.id_ex_en,
                 if3.id_ex_flush, if3.ex_mem_en, if3.mem_wb_en};
  assign st_c[0] = sc1;          assign st_c[1] = 32'(sc3);
  assign fl_c[0] = fc1;          assign fl_c[1] = 32'(fc3);
  assign mw_c[0] = mc1;          assign mw_c[1] = 32'(mc3);

  // ---------------- reference model ----------------
  // Tracks only "bubbles still owed" and event counts.
  int    lat [2]  = '{1, 3};
  longint cmax [2] = '{64'hFFFF_FFFF, 64'd7};
  int    owed [2];
  longint m_st [2], m_fl [2], m_mw [2];

  function automatic bit ref_hz();
    return isld && regwr && (exrd != 0) &&
           ((u1 && rs1 == exrd) || (u2 && rs2 == exrd));
  endfunction

  function automatic logic [6:0] model_out(int k);
    if (!resetn)                 return V_RST;
    if (dreq && !drdy)           return V_FREEZE;
    if (redir)                   return V_FLUSH;
    if (owed[k] > 0 || ref_hz()) return V_BUB;
    return V_NORM;
  endfunction

  function automatic longint bump(longint v, int k);
    if (!PERF) return 0;
    return (v < cmax[k]) ? v + 1 : v;
  endfunction

  task automatic model_advance();
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        owed[k] = 0; m_st[k] = 0; m_fl[k] = 0; m_mw[k] = 0;
      end else if (dreq && !drdy) begin
        m_mw[k] = bump(m_mw[k], k);
      end else if (redir) begin
        owed[k] = 0;
        m_fl[k] = bump(m_fl[k], k);
      end else if (owed[k] > 0) begin
        owed[k]--;
        m_st[k] = bump(m_st[k], k);
      end else if (ref_hz()) begin
        owed[k] = lat[k] - 1;
        m_st[k] = bump(m_st[k], k);
      end
    end
  endtask

  function automatic int unsigned pexp(int unsigned v);
    return PERF ? v : 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_neutral();
    rs1 = 5'd1; rs2 = 5'd2; u1 = 1'b1; u2 = 1'b1;
    exrd = 5'd9; regwr = 1'b1; isld = 1'b0;
    redir = 1'b0; dreq = 1'b0; drdy = 1'b0;
  endtask

  task automatic set_hazard();
    set_neutral();
    isld = 1'b1; regwr = 1'b1; exrd = 5'd5; rs1 = 5'd5; u1 = 1'b1;
  endtask

  // One clock: update model with the inputs of this cycle, log, advance.
  task automatic tick();
    $display("cyc=%0d rstn=%b hz=%b redir=%b dreq=%b drdy=%b lat1_out=%b lat3_out=%b",
             cyc, resetn, ref_hz(), redir, dreq, drdy, o[0], o[1]);
    model_advance();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    set_neutral();
    #1;
    tick();
    resetn = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    set_hazard();
    redir = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o[k] !== V_RST) begin
        failures++;
        $display("FAIL reset_outputs dut%0d got=%b want=%b", k, o[k], V_RST);
      end
    end
    tick();
    resetn = 1'b1;
    set_neutral();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o[k] !== V_NORM) begin
        failures++;
        $display("FAIL after_reset_outputs dut%0d got=%b want=%b", k, o[k], V_NORM);
      end
      checks++;
      if (st_c[k] !== 0 || fl_c[k] !== 0 || mw_c[k] !== 0) begin
        failures++;
        $display("FAIL reset_counters dut%0d got=%0d/%0d/%0d want=0/0/0",
                 k, st_c[k], fl_c[k], mw_c[k]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [6:0] want [2];
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) set_hazard(); else set_neutral();
      #1;
      want[0] = (c < 1) ? V_BUB : V_NORM;
      want[1] = (c < 3) ? V_BUB : V_NORM;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o[k] !== want[k]) begin
          failures++;
          $display("FAIL load_use c%0d dut%0d got=%b want=%b", c, k, o[k], want[k]);
        end
      end
      tick();
    end
    set_neutral();
    #1;
    checks++;
    if (st_c[0] !== pexp(1)) begin
      failures++;
      $display("FAIL load_use_stall_cnt lat1 got=%0d want=%0d", st_c[0], pexp(1));
    end
    checks++;
    if (st_c[1] !== pexp(3)) begin
      failures++;
      $display("FAIL load_use_stall_cnt lat3 got=%0d want=%0d", st_c[1], pexp(3));
    end
  endtask

  task automatic test_no_hazard();
    logic [6:0] want;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      set_hazard();
      case (c)
        0: begin exrd = 5'd0; rs1 = 5'd0; want = V_NORM; end   // x0 never hazards
        1: begin exrd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; u2 = 1'b0; want = V_NORM; end
        default: begin exrd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; u2 = 1'b1; want = V_BUB; end
      endcase
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o[k] !== want) begin
          failures++;
          $display("FAIL no_hazard c%0d dut%0d got=%b want=%b", c, k, o[k], want);
        end
      end
      if (c < 2) tick();
    end
  endtask

  task automatic test_redirect_in_stall();
    logic [6:0] want [3];
    want[0] = V_BUB; want[1] = V_FLUSH; want[2] = V_NORM;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) set_hazard(); else set_neutral();
      redir = (c == 1);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o[k] !== want[c]) begin
          failures++;
          $display("FAIL redirect_in_stall c%0d dut%0d got=%b want=%b", c, k, o[k], want[c]);
        end
      end
      tick();
    end
    set_neutral();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o[k] !== V_NORM || fl_c[k] !== pexp(1) || st_c[k] !== pexp(1)) begin
        failures++;
        $display("FAIL redirect_in_stall_after dut%0d got=%b fl=%0d st=%0d want=%b fl=%0d st=%0d",
                 k, o[k], fl_c[k], st_c[k], V_NORM, pexp(1), pexp(1));
      end
    end
  endtask

  task automatic test_memwait_redirect();
    logic [6:0] want;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      set_neutral();
      if (c < 5) begin redir = 1'b1; dreq = 1'b1; drdy = (c == 4); end
      want = (c < 4) ? V_FREEZE : (c == 4) ? V_FLUSH : V_NORM;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o[k] !== want) begin
          failures++;
          $display("FAIL memwait_redirect c%0d dut%0d got=%b want=%b", c, k, o[k], want);
        end
      end
      tick();
    end
    set_neutral();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mw_c[k] !== pexp(4) || fl_c[k] !== pexp(1)) begin
        failures++;
        $display("FAIL memwait_counts dut%0d got mw=%0d fl=%0d want mw=%0d fl=%0d",
                 k, mw_c[k], fl_c[k], pexp(4), pexp(1));
      end
    end
  endtask

  task automatic test_freeze_in_stall();
    logic [6:0] want [2];
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) set_hazard(); else set_neutral();
      if (c == 1) begin dreq = 1'b1; drdy = 1'b0; end
      want[0] = (c == 0) ? V_BUB : (c == 1) ? V_FREEZE : V_NORM;
      want[1] = (c == 1) ? V_FREEZE : (c < 4) ? V_BUB : V_NORM;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o[k] !== want[k]) begin
          failures++;
          $display("FAIL freeze_in_stall c%0d dut%0d got=%b want=%b", c, k, o[k], want[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_in_mwait();
    logic [6:0] want;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      set_neutral();
      if (c < 3) begin dreq = 1'b1; drdy = 1'b0; end
      resetn = (c != 2);
      want = (c < 2) ? V_FREEZE : (c == 2) ? V_RST : V_NORM;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o[k] !== want) begin
          failures++;
          $display("FAIL reset_in_mwait c%0d dut%0d got=%b want=%b", c, k, o[k], want);
        end
      end
      if (c == 3) begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (st_c[k] !== 0 || fl_c[k] !== 0 || mw_c[k] !== 0) begin
            failures++;
            $display("FAIL reset_in_mwait_counters dut%0d got=%0d/%0d/%0d want=0/0/0",
                     k, st_c[k], fl_c[k], mw_c[k]);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [6:0] want;
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      resetn = ($urandom_range(0, 59) != 0);
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      exrd  = 5'($urandom_range(0, 3));
      u1    = 1'($urandom_range(0, 1));
      u2    = 1'($urandom_range(0, 1));
      regwr = ($urandom_range(0, 3) != 0);
      isld  = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 7) == 0);
      dreq  = ($urandom_range(0, 2) == 0);
      drdy  = 1'($urandom_range(0, 1));
      #1;
      for (int k = 0; k < 2; k++) begin
        want = model_out(k);
        checks++;
        if (o[k] !== want) begin
          failures++;
          $display("FAIL random_outputs n%0d dut%0d got=%b want=%b", n, k, o[k], want);
        end
        checks++;
        if (st_c[k] !== 32'(m_st[k]) || fl_c[k] !== 32'(m_fl[k]) || mw_c[k] !== 32'(m_mw[k])) begin
          failures++;
          $display("FAIL random_counters n%0d dut%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                   n, k, st_c[k], fl_c[k], mw_c[k], m_st[k], m_fl[k], m_mw[k]);
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      owed[k] = 0; m_st[k] = 0; m_fl[k] = 0; m_mw[k] = 0;
    end
    resetn = 1'b0;
    set_neutral();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_no_hazard();
    test_redirect_in_stall();
    test_memwait_redirect();
    test_freeze_in_stall();
    test_reset_in_mwait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core. Drives the enable and flush inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. Resolves load-use hazards by inserting bubbles into ID_EX, squashes wrong-path instructions on EX redirects, and freezes the whole pipe while data memory is busy. Optionally keeps hazard performance counters.

Parameters:
LOAD_LAT, 1, bubbles inserted per load-use hazard (legal 1..3).
CNT_W, 32, width of each performance counter.

Ports:
clk  in  1  clock
resetn  in  1  reset
id_rs1  in  5  rs1 address of instruction in ID
id_rs2  in  5  rs2 address of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd address in EX (ID_EX output)
ex_reg_write  in  1  EX instruction writes rd
ex_is_load  in  1  EX instruction is a load
redirect  in  1  branch taken / jump resolved in EX
dmem_req  in  1  MEM stage access in progress
dmem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC update enable
if_id_en  out  1  IF_ID load enable
if_id_flush  out  1  IF_ID clear to NOP
id_ex_en  out  1  ID_EX load enable
id_ex_flush  out  1  ID_EX load bubble (all control fields 0)
ex_mem_en  out  1  EX_MEM load enable
mem_wb_en  out  1  MEM_WB load enable
stall_cnt  out  CNT_W  load-use bubble cycles
flush_cnt  out  CNT_W  redirect events
memwait_cnt  out  CNT_W  memory freeze cycles

Behaviour:
- Interface: reset resetn, synchronous, active-low; clock clk.
- State register with three states: RUN, STALL, MWAIT. A down-counter bub_left (2 bits) is also registered. Outputs are combinational from state, bub_left and inputs.
- While resetn=0:
  - All *_en outputs are 0, and if_id_flush=1, id_ex_flush=1.
  - On the clock edge, the state goes to RUN, bub_left to 0, and all counters to 0.
  - A reset mid-stall or mid-freeze abandons that stall or freeze.
- Condition definitions:
  - memstall = dmem_req & !dmem_ready.
  - hz = ex_is_load & ex_reg_write & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Priority per cycle, highest first: memstall, then redirect, then hazard / STALL.
- memstall, in any state:
  - All five enables are 0 and both flushes are 0.
  - If the state was RUN, go to MWAIT. If the state was STALL, stay in STALL with bub_left frozen.
  - A pending redirect or hz is not acted on. It is re-evaluated when memstall drops, because the inputs are held by the frozen pipe.
- MWAIT:
  - Stays in MWAIT while memstall=1.
  - On the first cycle with memstall=0, behaves exactly as RUN in that same cycle, with no extra bubble.
- redirect (no memstall):
  - pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
  - Next state is RUN and bub_left=0. This also aborts an in-progress STALL.
- RUN with hz (no memstall, no redirect):
  - pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
  - If LOAD_LAT=1, stay in RUN. Otherwise go to STALL with bub_left=LOAD_LAT-1.
- STALL (no memstall, no redirect):
  - Same outputs as RUN with hz.
  - bub_left decrements each cycle. When bub_left is 1 at the edge, go to RUN.
  - hz is not re-checked inside STALL.
- RUN with no event: all enables 1, flushes 0.
- Latency: a load-use hazard costs exactly LOAD_LAT cycles. A redirect costs 2 squashed slots with 0 extra cycles.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined, counters increment on the edge, unless resetn=0:
  - stall_cnt increments on each cycle in which a hazard/STALL bubble is issued.
  - flush_cnt increments on each cycle in which redirect is acted on.
  - memwait_cnt increments on each cycle with memstall=1.
  - All counters saturate at all-ones (no wrap).
- When not defined, the counter registers are not built and all three outputs are constant 0.

Test Plan:
- Load-use, LOAD_LAT=1: ex_is_load=1, ex_reg_write=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle (EX now holds a bubble) all enables 1.
- LOAD_LAT=3, same hazard -> exactly 3 consecutive bubble cycles (pc_en=0), then RUN; stall_cnt=3 with HAZ_PERF_CNT_EN.
- ex_rd=0, or id_rs2 matching with id_uses_rs2=0 -> no stall; all enables 1.
- redirect=1 in cycle 2 of a LOAD_LAT=3 stall -> if_id_flush=1, id_ex_flush=1, pc_en=1 that cycle; state RUN next cycle; flush_cnt=1.
- dmem_req=1 with dmem_ready low for 4 cycles while redirect=1 -> 4 cycles with all enables 0 and no flush; on the 5th cycle the flush fires once; memwait_cnt=4.
- resetn=0 for 1 cycle during MWAIT -> enables 0 and flushes 1 during reset; RUN afterwards; counters 0.
